// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator keypad entry path.
//   state_t    : entry controller states
//   DATA_W     : operand width
//   MAX_DIGITS : decimal digits an operand may hold
//   MAX_VAL    : largest operand value representable in DATA_W bits
// ----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no digits held
        ENTRY = 2'd1,   // 1..MAX_DIGITS digits held
        WRITE = 2'd2,   // single-cycle register-file write strobe
        CLEAR = 2'd3    // single-cycle register-file clear strobe
    } state_t;

    localparam int DATA_W     = 8;
    localparam int MAX_DIGITS = 3;
    localparam int MAX_VAL    = 255;

endpackage

// File: rtl/operand_entry_if.sv
// ----------------------------------------------------------------------------
// operand_entry_if
// Bundles the keypad strobes, the register-file write/clear port and the
// display status of the operand entry controller.
//   master : keypad side, drives key strobes, observes everything else
//   slave  : operand_entry, consumes key strobes, drives port and status
// Signals:
//   digit_valid, digit, key_enter, key_del, key_clear  (keypad strobes)
//   write_data, write_enable, write_address, regs_clear (register file)
//   entry_value, digit_count, slot_ptr, full, err       (display status)
// ----------------------------------------------------------------------------
interface operand_entry_if #(
    parameter int ADDR_W = 4
);
    import calc_pkg::*;

    logic              digit_valid;
    logic [3:0]        digit;
    logic              key_enter;
    logic              key_del;
    logic              key_clear;

    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic              regs_clear;

    logic [DATA_W-1:0] entry_value;
    logic [1:0]        digit_count;
    logic [ADDR_W-1:0] slot_ptr;
    logic              full;
    logic              err;

    modport master (
        output digit_valid, digit, key_enter, key_del, key_clear,
        input  write_data, write_enable, write_address, regs_clear,
        input  entry_value, digit_count, slot_ptr, full, err
    );

    modport slave (
        input  digit_valid, digit, key_enter, key_del, key_clear,
        output write_data, write_enable, write_address, regs_clear,
        output entry_value, digit_count, slot_ptr, full, err
    );

endinterface

// File: rtl/dec_accum.sv
// ----------------------------------------------------------------------------
// dec_accum
// Combinational decimal arithmetic for the operand entry controller.
//   value    in  current operand
//   count    in  digits currently held
//   digit    in  candidate BCD digit (10..15 invalid)
//   appended out value*10 + digit (low DATA_W bits)
//   fits     out candidate digit is valid, a digit slot is free and the
//                appended value stays within MAX_VAL
//   divided  out value/10, i.e. the operand with its last digit removed
// ----------------------------------------------------------------------------
module dec_accum
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        count,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] appended,
    output logic              fits,
    output logic [DATA_W-1:0] divided
);

    // 10 bits suffice because an append is only accepted with fewer than
    // MAX_DIGITS digits held, which bounds value at 99.
    logic [9:0] wide;

    assign wide     = ({2'b00, value} * 10'd10) + {6'b000000, digit};
    assign appended = wide[DATA_W-1:0];
    assign fits     = (digit <= 4'd9) &&
                      (count < MAX_DIGITS[1:0]) &&
                      (wide <= MAX_VAL[9:0]);
    assign divided  = value / 8'd10;

endmodule

// File: rtl/operand_entry.sv
// ----------------------------------------------------------------------------
// operand_entry
// Keypad-side entry controller in front of the calculator register file.
// Accumulates up to three decimal digits into an 8-bit operand, supports
// delete-last-digit, commits the operand on Enter to the next register slot
// and issues a one-cycle register-file clear on Clear.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of operand_entry_if (keys in, write port/status out)
// Parameters:
//   NUM_OPS  operand slots, filled 0..NUM_OPS-1 (<= 2**ADDR_W)
//   ADDR_W   width of write_address / slot_ptr
// ----------------------------------------------------------------------------
module operand_entry
    import calc_pkg::*;
#(
    parameter int NUM_OPS = 3,
    parameter int ADDR_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    operand_entry_if.slave bus
);

    localparam logic [ADDR_W:0] LastSlot = NUM_OPS[ADDR_W:0];

    state_t            state,      stateNext;
    logic [DATA_W-1:0] entryValue, entryNext;
    logic [1:0]        digitCount, countNext;
    logic [ADDR_W-1:0] slotPtr,    slotNext;
    logic              full,       fullNext;
    logic [DATA_W-1:0] writeData,  writeDataNext;
    logic [ADDR_W-1:0] writeAddr,  writeAddrNext;
    logic              err,        errNext;

    logic [DATA_W-1:0] appended;
    logic [DATA_W-1:0] divided;
    logic              fits;
    logic [ADDR_W:0]   slotInc;
    logic              otherKey;

    dec_accum accum (
        .value    (entryValue),
        .count    (digitCount),
        .digit    (bus.digit),
        .appended (appended),
        .fits     (fits),
        .divided  (divided)
    );

    // Extra bit so "all slots used" is detectable even at NUM_OPS == 2**ADDR_W.
    assign slotInc  = {1'b0, slotPtr} + {{ADDR_W{1'b0}}, 1'b1};
    assign otherKey = bus.digit_valid | bus.key_enter | bus.key_del;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            entryValue <= '0;
            digitCount <= '0;
            slotPtr    <= '0;
            full       <= 1'b0;
            writeData  <= '0;
            writeAddr  <= '0;
            err        <= 1'b0;
        end else begin
            state      <= stateNext;
            entryValue <= entryNext;
            digitCount <= countNext;
            slotPtr    <= slotNext;
            full       <= fullNext;
            writeData  <= writeDataNext;
            writeAddr  <= writeAddrNext;
            err        <= errNext;
        end
    end

    always_comb begin
        stateNext     = state;
        entryNext     = entryValue;
        countNext     = digitCount;
        slotNext      = slotPtr;
        fullNext      = full;
        writeDataNext = writeData;
        writeAddrNext = writeAddr;
        errNext       = 1'b0;

        case (state)
            WRITE: begin
                // The write completes regardless of keys; a clear seen now
                // runs straight after, any other key is rejected.
                slotNext  = slotInc[ADDR_W-1:0];
                fullNext  = (slotInc == LastSlot);
                entryNext = '0;
                countNext = '0;
                if (bus.key_clear) begin
                    stateNext = CLEAR;
                end else begin
                    stateNext = IDLE;
                    errNext   = otherKey;
                end
            end

            CLEAR: begin
                slotNext  = '0;
                fullNext  = 1'b0;
                entryNext = '0;
                countNext = '0;
                stateNext = IDLE;
                errNext   = otherKey | bus.key_clear;
            end

            default: begin
                // IDLE / ENTRY: only the highest-priority strobe is acted on.
                if (bus.key_clear) begin
                    stateNext = CLEAR;
                end else if (bus.key_enter) begin
                    if ((state == ENTRY) && !full) begin
                        stateNext     = WRITE;
                        writeDataNext = entryValue;
                        writeAddrNext = slotPtr;
                    end else begin
                        errNext = 1'b1;
                    end
                end else if (bus.key_del) begin
                    if (state == ENTRY) begin
                        entryNext = divided;
                        countNext = digitCount - 2'd1;
                        if (digitCount == 2'd1) begin
                            stateNext = IDLE;
                        end
                    end
                end else if (bus.digit_valid) begin
                    // A leading zero is silently ignored.
                    if (!((bus.digit == 4'd0) && (digitCount == 2'd0))) begin
                        if (fits) begin
                            entryNext = appended;
                            countNext = digitCount + 2'd1;
                            stateNext = ENTRY;
                        end else begin
                            errNext = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Strobes decode straight from state so reset drops them asynchronously.
    assign bus.write_enable  = (state == WRITE);
    assign bus.regs_clear    = (state == CLEAR);
    assign bus.write_data    = writeData;
    assign bus.write_address = writeAddr;
    assign bus.entry_value   = entryValue;
    assign bus.digit_count   = digitCount;
    assign bus.slot_ptr      = slotPtr;
    assign bus.full          = full;
    assign bus.err           = err;

endmodule

// File: tb/tb_operand_entry.sv
// ----------------------------------------------------------------------------
// tb_operand_entry
// Self-checking bench for operand_entry: directed key sequences with literal
// expectations, then randomized key traffic, all compared every cycle against
// a digit-queue reference model.
// ----------------------------------------------------------------------------
module tb_operand_entry;

    localparam int NUM_OPS = 3;
    localparam int ADDR_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    operand_entry_if #(.ADDR_W(ADDR_W)) bus ();

    operand_entry #(.NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chkEn  = 1'b0;

    // Reference model: operand as a list of decimal digits, plus slot usage
    // and what the register-file port must show after the next edge.
    int q[$];
    int mSlot  = 0;
    bit mFull  = 1'b0;
    int mPhase = 0;      // 0 normal, 1 write strobe, 2 clear strobe
    bit mErr   = 1'b0;
    int mWd    = 0;
    int mWa    = 0;

    function automatic int qval();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mSlot  = 0;
        mFull  = 1'b0;
        mPhase = 0;
        mErr   = 1'b0;
        mWd    = 0;
        mWa    = 0;
    endtask

    task automatic modelStep(input bit dv, input int d, input bit en,
                             input bit dl, input bit cl);
        bit other;
        int nv;
        other = dv | en | dl;
        mErr  = 1'b0;
        if (mPhase == 1) begin
            mSlot++;
            mFull = (mSlot == NUM_OPS);
            q.delete();
            if (cl) mPhase = 2;
            else begin
                mPhase = 0;
                mErr   = other;
            end
        end else if (mPhase == 2) begin
            mSlot  = 0;
            mFull  = 1'b0;
            q.delete();
            mPhase = 0;
            mErr   = other | cl;
        end else if (cl) begin
            mPhase = 2;
        end else if (en) begin
            if (q.size() > 0 && !mFull) begin
                mPhase = 1;
                mWd    = qval();
                mWa    = mSlot;
            end else begin
                mErr = 1'b1;
            end
        end else if (dl) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (dv) begin
            nv = qval() * 10 + d;
            if (!(d == 0 && q.size() == 0)) begin
                if (d <= 9 && q.size() < 3 && nv <= 255) q.push_back(d);
                else mErr = 1'b1;
            end
        end
    endtask

    // Called at negedge+1: drive keys, advance the model to the state the
    // coming rising edge must produce, return at the following negedge+1.
    task automatic cycle(input bit dv, input int d, input bit en,
                         input bit dl, input bit cl);
        bus.digit_valid = dv;
        bus.digit       = d[3:0];
        bus.key_enter   = en;
        bus.key_del     = dl;
        bus.key_clear   = cl;
        modelStep(dv, d, en, dl, cl);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic dig(input int d);
        cycle(1, d, 0, 0, 0);
    endtask

    task automatic enter();
        cycle(0, 0, 1, 0, 0);
    endtask

    task automatic del();
        cycle(0, 0, 0, 1, 0);
    endtask

    task automatic clr();
        cycle(0, 0, 0, 0, 1);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            chk("entry_value",   int'(bus.entry_value),   qval());
            chk("digit_count",   int'(bus.digit_count),   q.size());
            chk("slot_ptr",      int'(bus.slot_ptr),      mSlot);
            chk("full",          int'(bus.full),          int'(mFull));
            chk("err",           int'(bus.err),           int'(mErr));
            chk("write_enable",  int'(bus.write_enable),  int'(mPhase == 1));
            chk("regs_clear",    int'(bus.regs_clear),    int'(mPhase == 2));
            chk("write_data",    int'(bus.write_data),    mWd);
            chk("write_address", int'(bus.write_address), mWa);
            chk("strobe_excl",   int'(bus.write_enable & bus.regs_clear), 0);
        end
    end

    initial begin
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.key_enter   = 1'b0;
        bus.key_del     = 1'b0;
        bus.key_clear   = 1'b0;

        rst = 1'b1;
        modelReset();
        repeat (3) @(negedge clk);
        #1;
        rst   = 1'b0;
        chkEn = 1'b1;

        // Reset state
        chk("rst_entry", int'(bus.entry_value), 0);
        chk("rst_slot",  int'(bus.slot_ptr), 0);
        chk("rst_we",    int'(bus.write_enable), 0);
        chk("rst_full",  int'(bus.full), 0);

        // 1,2,3 Enter
        dig(1);  chk("e1_val", int'(bus.entry_value), 1);
        dig(2);  chk("e12_val", int'(bus.entry_value), 12);
        dig(3);  chk("e123_val", int'(bus.entry_value), 123);
        enter();
        chk("w123_we", int'(bus.write_enable), 1);
        chk("w123_wd", int'(bus.write_data), 123);
        chk("w123_wa", int'(bus.write_address), 0);
        idle();
        chk("w123_slot", int'(bus.slot_ptr), 1);
        chk("w123_cnt",  int'(bus.digit_count), 0);
        chk("w123_we_off", int'(bus.write_enable), 0);

        // 2,5,6 overflow, then 255, then 4th digit
        dig(2); dig(5); dig(6);
        chk("ovf_err", int'(bus.err), 1);
        chk("ovf_val", int'(bus.entry_value), 25);
        dig(5);
        chk("v255_val", int'(bus.entry_value), 255);
        chk("v255_err", int'(bus.err), 0);
        dig(1);
        chk("d4_err", int'(bus.err), 1);
        chk("d4_val", int'(bus.entry_value), 255);
        clr();
        chk("clr1_rc", int'(bus.regs_clear), 1);
        chk("clr1_we", int'(bus.write_enable), 0);
        idle();
        chk("clr1_slot", int'(bus.slot_ptr), 0);

        // 4,7,Del,9 Enter -> 49; Del in IDLE
        dig(4); dig(7); del();
        chk("del_val", int'(bus.entry_value), 4);
        dig(9); enter();
        chk("w49_wd", int'(bus.write_data), 49);
        idle();
        del();
        chk("del_idle_err", int'(bus.err), 0);
        chk("del_idle_val", int'(bus.entry_value), 0);

        // Fill 10,20,30 then reject a fourth Enter
        clr(); idle();
        dig(1); dig(0); enter(); chk("w10_wa", int'(bus.write_address), 0); idle();
        dig(2); dig(0); enter(); chk("w20_wa", int'(bus.write_address), 1); idle();
        dig(3); dig(0); enter(); chk("w30_wa", int'(bus.write_address), 2); idle();
        chk("full_set", int'(bus.full), 1);
        dig(5);
        chk("full_digit_val", int'(bus.entry_value), 5);
        enter();
        chk("full_enter_err", int'(bus.err), 1);
        chk("full_enter_we",  int'(bus.write_enable), 0);

        // Clear after two writes, next operand lands at 0
        clr(); idle();
        dig(1); dig(0); enter(); idle();
        dig(2); dig(0); enter(); idle();
        clr();
        chk("clr2_rc", int'(bus.regs_clear), 1);
        chk("clr2_we", int'(bus.write_enable), 0);
        idle();
        chk("clr2_slot", int'(bus.slot_ptr), 0);
        chk("clr2_full", int'(bus.full), 0);
        dig(7); enter();
        chk("w7_wa", int'(bus.write_address), 0);
        chk("w7_wd", int'(bus.write_data), 7);
        idle();

        // Enter + Clear together; Clear during WRITE
        dig(3);
        cycle(0, 0, 1, 0, 1);
        chk("ec_rc", int'(bus.regs_clear), 1);
        chk("ec_we", int'(bus.write_enable), 0);
        idle();
        dig(8); enter();
        chk("cw_we", int'(bus.write_enable), 1);
        clr();
        chk("cw_rc",  int'(bus.regs_clear), 1);
        chk("cw_err", int'(bus.err), 0);
        chk("cw_slot", int'(bus.slot_ptr), 1);
        idle();
        chk("cw_slot0", int'(bus.slot_ptr), 0);

        // Asynchronous reset in the middle of a write strobe
        dig(6); enter();
        chk("ar_we_pre", int'(bus.write_enable), 1);
        chkEn = 1'b0;
        rst = 1'b1;
        #1;
        chk("ar_we", int'(bus.write_enable), 0);
        chk("ar_rc", int'(bus.regs_clear), 0);
        modelReset();
        chkEn = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit dv, en, dl, cl;
            int d;
            dv = ($urandom_range(0, 99) < 45);
            en = ($urandom_range(0, 99) < 12);
            dl = ($urandom_range(0, 99) < 10);
            cl = ($urandom_range(0, 99) < 3);
            d  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15)
                                             : $urandom_range(0, 9);
            cycle(dv, d, en, dl, cl);
        end

        chkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
